writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-side driver for the 8-bit register file.
- Collects results from two producers: single-cycle ALU results, and in-order returning memory loads tagged at issue.
- Serialises them onto the register file's rd / write_data / reg_write / label_write inputs.
- Keeps a busy scoreboard for general and label registers so decode can stall on pending loads.

Parameters:
- DATA_W, 8, data width of register file entries
- ADDR_W, 3, register address width
- NUM_REGS, 6, registers per file (general a0-a3/v0/c0; labels l0-l5)
- LD_DEPTH, 2, maximum outstanding loads (tag FIFO depth, power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  ADDR_W  ALU destination
- alu_label  in  1  1 = destination is the label file
- alu_data  in  DATA_W  ALU result
- ld_issue  in  1  load issued this cycle
- ld_rd  in  ADDR_W  load destination
- ld_label  in  1  1 = load targets the label file
- ld_issue_ready  out  1  load may issue
- mem_rvalid  in  1  load data returning (in issue order)
- mem_rdata  in  DATA_W  load data
- chk_rs1  in  ADDR_W  decode source 1
- chk_rs2  in  ADDR_W  decode source 2
- chk_label  in  1  sources read from the label file
- hazard  out  1  a source is not yet written
- rd  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- reg_write  out  1  general-file write strobe
- label_write  out  1  label-file write strobe
- pending_cnt  out  $clog2(LD_DEPTH)+1  outstanding loads
- err  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high, named `reset`.
- Reset state: rd=0, write_data=0, reg_write=0, label_write=0, err=0, pending_cnt=0; tag FIFO empty; all busy bits cleared. Reset mid-operation discards outstanding load tags; data returning after reset sets err.
- Output stage: one registered write slot. A strobe is asserted exactly one cycle after its source is accepted and lasts one cycle. reg_write and label_write are never both 1.
- Memory return:
  - mem_rvalid with a non-empty FIFO pops the head tag {label, rd}.
  - The next cycle drives rd=tag.rd and write_data=mem_rdata, with reg_write=~label / label_write=label.
  - The same edge clears the busy bit of tag.rd in its file.
  - mem_rvalid with an empty FIFO: data dropped, err set.
- ALU path:
  - alu_ready = ~mem_rvalid & ~busy[alu_label][alu_rd]. Memory return has priority; the ALU is also held off from a register with a pending load (WAW).
  - Accept = alu_valid & alu_ready; the write follows next cycle.
- Load issue:
  - ld_issue_ready = (pending_cnt < LD_DEPTH) & ~busy[ld_label][ld_rd].
  - Issue with ld_issue_ready pushes the tag and sets the busy bit.
  - Issue without ld_issue_ready: ignored, err set.
  - Simultaneous pop and push are legal at full; the count is unchanged.
- Invalid destination: any destination >= NUM_REGS (ALU, load, or popped tag) produces no write strobe and sets err. An ALU result is still accepted and a load still issues/pops, but no busy bit is set.
- Hazard (combinational): hazard=1 if, in the file selected by chk_label, either
  - chk_rs1 or chk_rs2 is busy, or
  - the output stage strobe is active with rd matching a source. The register file has not yet committed that value.
- pending_cnt equals FIFO occupancy and updates on the same edge as push/pop.
- err clears only on reset.

Decomposition:
- Package wb_pkg: DATA_W, ADDR_W, NUM_REGS constants; typedef wb_tag_t {logic label; logic [ADDR_W-1:0] rd}.
- Sub-module load_tag_fifo: LD_DEPTH-entry synchronous FIFO of wb_tag_t with push, pop, full, empty, count. It tolerates push+pop in the same cycle when full and when empty (an empty push+pop is not used by writeback_unit).

Test Plan:
- After reset, alu_valid=1, alu_rd=2, alu_label=0, alu_data=0x5A → next cycle rd=2, write_data=0x5A, reg_write=1, label_write=0, for one cycle only.
- ld_issue rd=1 label=1 → pending_cnt=1; chk_label=1, chk_rs1=1 → hazard=1. Then mem_rvalid with mem_rdata=0x33 → next cycle label_write=1, rd=1, write_data=0x33; hazard=1 during the strobe, 0 the cycle after; pending_cnt=0.
- Two loads issued (rd 0 then 3) with LD_DEPTH=2 → ld_issue_ready=0. Returns 0x11 then 0x22 → rd 0 gets 0x11 and rd 3 gets 0x22, in order.
- alu_valid and mem_rvalid in the same cycle → alu_ready=0, load written first; ALU write (alu_rd not busy) lands one cycle later with no data lost.
- Load pending to general r4, alu_rd=4 → alu_ready=0 until the load strobe; afterwards the ALU value overwrites.
- mem_rvalid with FIFO empty, and separately alu_rd=7 → no strobes, err=1 and remains 1 until reset; reset asserted with 2 loads pending → pending_cnt=0, busy cleared, outputs 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, register-file geometry and the load tag format for the writeback path.
package wb_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 6;

  typedef struct packed {
    logic              label;
    logic [ADDR_W-1:0] rd;
  } wb_tag_t;

  // Only addresses below NUM_REGS exist in either file.
  function automatic logic reg_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// Producer, decode-check and register-file write signals of the writeback unit.
interface writeback_unit_if
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 2
);
  localparam int CNT_W = $clog2(LD_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic              alu_label;
  logic [DATA_W-1:0] alu_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_rd;
  logic              ld_label;
  logic              ld_issue_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic              chk_label;
  logic              hazard;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              label_write;
  logic [CNT_W-1:0]  pending_cnt;
  logic              err;

  modport master (
    output alu_valid, alu_rd, alu_label, alu_data,
    output ld_issue, ld_rd, ld_label, mem_rvalid, mem_rdata,
    output chk_rs1, chk_rs2, chk_label,
    input  alu_ready, ld_issue_ready, hazard,
    input  rd, write_data, reg_write, label_write, pending_cnt, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_label, alu_data,
    input  ld_issue, ld_rd, ld_label, mem_rvalid, mem_rdata,
    input  chk_rs1, chk_rs2, chk_label,
    output alu_ready, ld_issue_ready, hazard,
    output rd, write_data, reg_write, label_write, pending_cnt, err
  );
endinterface

// File: rtl/load_tag_fifo.sv
// In-order tag queue for outstanding loads; combinational head, count updates on the push/pop edge.
// Latency: a pushed tag is visible at head the next cycle; push+pop legal when full or empty.
module load_tag_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_tag_t       push_tag,
  input  logic          pop,
  output wb_tag_t       head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  wb_tag_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & (~empty | push);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and in-order load returns into one registered register-file write, with a busy scoreboard.
// Latency: one cycle from accept/return to strobe; load return has priority and stalls the ALU via alu_ready.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  writeback_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(LD_DEPTH) + 1;

  // Row 0 = general file, row 1 = label file; entries >= NUM_REGS are never set.
  logic [1:0][2**ADDR_W-1:0] busy;

  wb_tag_t           head;
  wb_tag_t           nxt_tag;
  logic [DATA_W-1:0] nxt_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              alu_acc;
  logic              wr_go;
  logic              wr_ok;
  logic              strobe_sel;

  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic              reg_write_q;
  logic              label_write_q;
  logic              err_q;

  load_tag_fifo #(.DEPTH(LD_DEPTH)) u_tags (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag ({bus.ld_label, bus.ld_rd}),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign pop                = bus.mem_rvalid & ~fifo_empty;
  assign push               = bus.ld_issue & bus.ld_issue_ready;
  assign alu_acc            = bus.alu_valid & bus.alu_ready;
  assign bus.alu_ready      = ~bus.mem_rvalid & ~busy[bus.alu_label][bus.alu_rd];
  assign bus.ld_issue_ready = ~fifo_full & ~busy[bus.ld_label][bus.ld_rd];
  assign bus.pending_cnt    = count;
  assign bus.rd             = rd_q;
  assign bus.write_data     = data_q;
  assign bus.reg_write      = reg_write_q;
  assign bus.label_write    = label_write_q;
  assign bus.err            = err_q;

  always_comb begin
    nxt_tag  = head;
    nxt_data = bus.mem_rdata;
    wr_go    = pop;
    if (!pop) begin
      nxt_tag  = '{label: bus.alu_label, rd: bus.alu_rd};
      nxt_data = bus.alu_data;
      wr_go    = alu_acc;
    end
    wr_ok = wr_go & reg_ok(nxt_tag.rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q          <= '0;
      data_q        <= '0;
      reg_write_q   <= 1'b0;
      label_write_q <= 1'b0;
      err_q         <= 1'b0;
      busy          <= '0;
    end else begin
      reg_write_q   <= wr_ok & ~nxt_tag.label;
      label_write_q <= wr_ok & nxt_tag.label;
      if (wr_ok) begin
        rd_q   <= nxt_tag.rd;
        data_q <= nxt_data;
      end
      if (pop && reg_ok(head.rd))     busy[head.label][head.rd]     <= 1'b0;
      if (push && reg_ok(bus.ld_rd))  busy[bus.ld_label][bus.ld_rd] <= 1'b1;
      if ((bus.mem_rvalid & fifo_empty) | (bus.ld_issue & ~bus.ld_issue_ready) |
          (wr_go & ~reg_ok(nxt_tag.rd)) | (push & ~reg_ok(bus.ld_rd)))
        err_q <= 1'b1;
    end
  end

  // A write in the output stage is not yet in the register file, so it still hazards.
  always_comb begin
    strobe_sel = bus.chk_label ? label_write_q : reg_write_q;
    bus.hazard = busy[bus.chk_label][bus.chk_rs1] | busy[bus.chk_label][bus.chk_rs2] |
                 (strobe_sel & ((rd_q == bus.chk_rs1) | (rd_q == bus.chk_rs2)));
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU writes, load returns, priority, WAW stall, error and reset cases.
module tb_writeback_unit;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  writeback_unit_if #(.LD_DEPTH(2)) bus ();

  writeback_unit #(.LD_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid  = 1'b0; bus.alu_rd  = '0; bus.alu_label = 1'b0; bus.alu_data = '0;
    bus.ld_issue   = 1'b0; bus.ld_rd   = '0; bus.ld_label  = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.chk_rs1    = '0;   bus.chk_rs2 = '0; bus.chk_label = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    settle();
  endtask

  task automatic issue(input logic [ADDR_W-1:0] r, input logic lab);
    bus.ld_issue = 1'b1; bus.ld_rd = r; bus.ld_label = lab;
    step();
    bus.ld_issue = 1'b0;
    settle();
  endtask

  task automatic check_write(input string tag, input logic [ADDR_W-1:0] r,
                             input logic [DATA_W-1:0] d, input logic gen, input logic lab);
    check({tag, "_rd"},   16'(bus.rd), 16'(r));
    check({tag, "_data"}, 16'(bus.write_data), 16'(d));
    check({tag, "_rw"},   16'(bus.reg_write), 16'(gen));
    check({tag, "_lw"},   16'(bus.label_write), 16'(lab));
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check("rst_rd",   16'(bus.rd), 16'h0);
    check("rst_data", 16'(bus.write_data), 16'h0);
    check("rst_rw",   16'(bus.reg_write), 16'h0);
    check("rst_lw",   16'(bus.label_write), 16'h0);
    check("rst_err",  16'(bus.err), 16'h0);
    check("rst_cnt",  16'(bus.pending_cnt), 16'h0);
    check("rst_haz",  16'(bus.hazard), 16'h0);

    // ALU write to general r2
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_label = 1'b0; bus.alu_data = 8'h5A;
    settle();
    check("alu_rdy", 16'(bus.alu_ready), 16'h1);
    step();
    bus.alu_valid = 1'b0;
    check_write("alu", 3'd2, 8'h5A, 1'b1, 1'b0);
    step();
    check("alu_once", 16'(bus.reg_write), 16'h0);

    // Label load l1, hazard tracking through the strobe
    issue(3'd1, 1'b1);
    check("ld1_cnt", 16'(bus.pending_cnt), 16'h1);
    bus.chk_label = 1'b1; bus.chk_rs1 = 3'd1; bus.chk_rs2 = 3'd0;
    settle();
    check("ld1_haz_busy", 16'(bus.hazard), 16'h1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h33;
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check_write("ld1", 3'd1, 8'h33, 1'b0, 1'b1);
    check("ld1_haz_strobe", 16'(bus.hazard), 16'h1);
    check("ld1_cnt0", 16'(bus.pending_cnt), 16'h0);
    step();
    check("ld1_lw_off", 16'(bus.label_write), 16'h0);
    check("ld1_haz_off", 16'(bus.hazard), 16'h0);
    bus.chk_label = 1'b0;

    // Two loads fill the tag queue, return in order
    issue(3'd0, 1'b0);
    issue(3'd3, 1'b0);
    bus.ld_rd = 3'd5;
    settle();
    check("full_cnt", 16'(bus.pending_cnt), 16'h2);
    check("full_rdy", 16'(bus.ld_issue_ready), 16'h0);
    bus.chk_rs1 = 3'd3; bus.chk_rs2 = 3'd4;
    settle();
    check("full_haz", 16'(bus.hazard), 16'h1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h11;
    step();
    check_write("ret0", 3'd0, 8'h11, 1'b1, 1'b0);
    bus.mem_rdata = 8'h22;
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check_write("ret1", 3'd3, 8'h22, 1'b1, 1'b0);
    check("ret_cnt", 16'(bus.pending_cnt), 16'h0);
    step();

    // Load return beats a simultaneous ALU result
    issue(3'd2, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h44;
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_label = 1'b0; bus.alu_data = 8'h77;
    settle();
    check("pri_alu_rdy0", 16'(bus.alu_ready), 16'h0);
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check("pri_alu_rdy1", 16'(bus.alu_ready), 16'h1);
    check_write("pri_ld", 3'd2, 8'h44, 1'b1, 1'b0);
    step();
    bus.alu_valid = 1'b0;
    check_write("pri_alu", 3'd5, 8'h77, 1'b1, 1'b0);
    step();

    // WAW: ALU to r4 waits on the pending load to r4
    issue(3'd4, 1'b0);
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd4; bus.alu_data = 8'h99;
    settle();
    check("waw_rdy0", 16'(bus.alu_ready), 16'h0);
    step();
    check("waw_nowr", 16'(bus.reg_write), 16'h0);
    check("waw_rdy0b", 16'(bus.alu_ready), 16'h0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h55;
    step();
    bus.mem_rvalid = 1'b0;
    settle();
    check_write("waw_ld", 3'd4, 8'h55, 1'b1, 1'b0);
    check("waw_rdy1", 16'(bus.alu_ready), 16'h1);
    step();
    bus.alu_valid = 1'b0;
    check_write("waw_alu", 3'd4, 8'h99, 1'b1, 1'b0);
    check("waw_err", 16'(bus.err), 16'h0);
    step();

    // Invalid ALU destination
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd7; bus.alu_data = 8'hEE;
    settle();
    check("bad_rd_rdy", 16'(bus.alu_ready), 16'h1);
    step();
    bus.alu_valid = 1'b0;
    check("bad_rd_rw", 16'(bus.reg_write), 16'h0);
    check("bad_rd_lw", 16'(bus.label_write), 16'h0);
    check("bad_rd_err", 16'(bus.err), 16'h1);
    do_reset();
    check("err_clr", 16'(bus.err), 16'h0);

    // Return with no load outstanding
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'hAB;
    step();
    bus.mem_rvalid = 1'b0;
    check("orphan_rw", 16'(bus.reg_write), 16'h0);
    check("orphan_err", 16'(bus.err), 16'h1);
    step();
    step();
    check("err_sticky", 16'(bus.err), 16'h1);

    // Reset with loads outstanding
    issue(3'd1, 1'b0);
    issue(3'd2, 1'b0);
    check("pre_rst_cnt", 16'(bus.pending_cnt), 16'h2);
    do_reset();
    bus.chk_label = 1'b0; bus.chk_rs1 = 3'd1; bus.chk_rs2 = 3'd2;
    bus.ld_rd = 3'd1;
    settle();
    check("mid_rst_cnt", 16'(bus.pending_cnt), 16'h0);
    check("mid_rst_haz", 16'(bus.hazard), 16'h0);
    check("mid_rst_ldrdy", 16'(bus.ld_issue_ready), 16'h1);
    check("mid_rst_rd", 16'(bus.rd), 16'h0);
    check("mid_rst_data", 16'(bus.write_data), 16'h0);
    check("mid_rst_err", 16'(bus.err), 16'h0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h5C;
    step();
    bus.mem_rvalid = 1'b0;
    check("late_ret_err", 16'(bus.err), 16'h1);
    check("late_ret_rw", 16'(bus.reg_write), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
